// File: rtl/nop_inserting_loader.sv
// Program loader that writes an instruction stream into pipeline memory and pads RAW hazards with
// NOP words. Define NOP_INSERT_STATS_EN to add the nop_count/instr_count outputs.
module nop_inserting_loader #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MIN_GAP  = 2,
  parameter logic [31:0] NOP_WORD = 32'h0C00_0000
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
`ifdef NOP_INSERT_STATS_EN
  output logic [ADDR_W-1:0] nop_count,
  output logic [ADDR_W-1:0] instr_count,
`endif
  output logic              overflow
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StDone = 2'd2;
  localparam logic [1:0] StErr  = 2'd3;

  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};
  localparam logic [5:0]        OpHlt    = 6'b111111;

  logic [1:0]              r_state, w_state_d;
  logic [ADDR_W-1:0]       r_ptr, w_ptr_d;
  logic [MIN_GAP-1:0]      r_hist_v, w_hist_v_d;
  logic [MIN_GAP-1:0][4:0] r_hist_r, w_hist_r_d;
  logic                    r_mem_we, w_mem_we_d;
  logic [ADDR_W-1:0]       r_mem_addr, w_mem_addr_d;
  logic [31:0]             r_mem_wdata, w_mem_wdata_d;

  logic [5:0] w_op;
  logic [4:0] w_rs, w_rt, w_rd, w_dst;
  logic       w_rs_v, w_rt_v, w_dst_v;
  logic       w_hazard, w_load, w_acc, w_nop, w_wr, w_is_hlt;

  assign w_op     = in_instr[31:26];
  assign w_rs     = in_instr[25:21];
  assign w_rt     = in_instr[20:16];
  assign w_rd     = in_instr[15:11];
  assign w_is_hlt = (w_op == OpHlt);

  // Source/destination decode of the word presented on in_instr.
  always_comb begin
    w_rs_v = 1'b0;
    w_rt_v = 1'b0;
    w_dst  = 5'd0;
    unique case (w_op)
      6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101: begin
        w_rs_v = 1'b1;
        w_rt_v = 1'b1;
        w_dst  = w_rd;
      end
      6'b001000, 6'b001010, 6'b001011, 6'b001100: begin
        w_rs_v = 1'b1;
        w_dst  = w_rt;
      end
      6'b001001: begin
        w_rs_v = 1'b1;
        w_rt_v = 1'b1;
      end
      6'b001101, 6'b001110: begin
        w_rs_v = 1'b1;
      end
      default: ;
    endcase
    w_dst_v = (w_dst != 5'd0);
  end

  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < MIN_GAP; i++) begin
      if (r_hist_v[i]) begin
        if (w_rs_v && (w_rs != 5'd0) && (w_rs == r_hist_r[i])) w_hazard = 1'b1;
        if (w_rt_v && (w_rt != 5'd0) && (w_rt == r_hist_r[i])) w_hazard = 1'b1;
      end
    end
  end

  // A start in LOAD wins over the handshake: nothing is accepted or written that cycle.
  assign w_load   = (r_state == StLoad) && !start;
  assign w_acc    = w_load && in_valid && !w_hazard;
  assign w_nop    = w_load && in_valid && w_hazard;
  assign w_wr     = w_acc || w_nop;
  assign in_ready = w_acc;

  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_hist_v_d    = r_hist_v;
    w_hist_r_d    = r_hist_r;
    w_mem_we_d    = 1'b0;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    if (start) begin
      w_state_d  = StLoad;
      w_ptr_d    = '0;
      w_hist_v_d = '0;
      w_hist_r_d = '0;
    end else if (w_wr) begin
      w_mem_we_d    = 1'b1;
      w_mem_addr_d  = r_ptr;
      w_mem_wdata_d = w_acc ? in_instr : NOP_WORD;
      w_ptr_d       = r_ptr + ADDR_W'(1);
      for (int i = MIN_GAP - 1; i > 0; i--) begin
        w_hist_v_d[i] = r_hist_v[i-1];
        w_hist_r_d[i] = r_hist_r[i-1];
      end
      w_hist_v_d[0] = w_acc && w_dst_v;
      w_hist_r_d[0] = w_acc ? w_dst : 5'd0;
      // HLT is checked first so a HLT landing in the last slot still completes cleanly.
      if (w_acc && w_is_hlt) begin
        w_state_d = StDone;
      end else if (r_ptr == LastAddr) begin
        w_state_d = StErr;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_hist_v    <= '0;
      r_hist_r    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_hist_v    <= w_hist_v_d;
      r_hist_r    <= w_hist_r_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state == StLoad);
  assign done      = (r_state == StDone);
  assign overflow  = (r_state == StErr);

`ifdef NOP_INSERT_STATS_EN
  logic [ADDR_W-1:0] r_nop_cnt, r_instr_cnt;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_nop_cnt   <= '0;
      r_instr_cnt <= '0;
    end else if (start) begin
      r_nop_cnt   <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (w_nop) r_nop_cnt <= r_nop_cnt + ADDR_W'(1);
      if (w_acc) r_instr_cnt <= r_instr_cnt + ADDR_W'(1);
    end
  end

  assign nop_count   = r_nop_cnt;
  assign instr_count = r_instr_cnt;
`endif

endmodule

// File: tb/tb_nop_inserting_loader.sv
// Bench for nop_inserting_loader: table-driven streams with a write scoreboard, plus hand-written
// restart, idle-gap, overflow and asynchronous-reset sequences on a small second instance.
module tb_nop_inserting_loader;

  localparam logic [31:0] NOP = 32'h0C00_0000;
  localparam logic [31:0] HLT = 32'hFC00_0000;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready, mem_we, busy, done, overflow;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;

  logic        s_start = 1'b0, s_in_valid = 1'b0;
  logic [31:0] s_in_instr = '0;
  logic        s_in_ready, s_mem_we, s_busy, s_done, s_overflow;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;

`ifdef NOP_INSERT_STATS_EN
  logic [9:0] nop_count, instr_count;
  logic [1:0] s_nop_count, s_instr_count;
`endif

  always #5 clk1 = ~clk1;

  nop_inserting_loader #(.ADDR_W(10), .MIN_GAP(2)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done),
`ifdef NOP_INSERT_STATS_EN
    .nop_count(nop_count), .instr_count(instr_count),
`endif
    .overflow(overflow)
  );

  nop_inserting_loader #(.ADDR_W(2), .MIN_GAP(2)) dut_small (
    .clk1(clk1), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_instr(s_in_instr), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .busy(s_busy), .done(s_done),
`ifdef NOP_INSERT_STATS_EN
    .nop_count(s_nop_count), .instr_count(s_instr_count),
`endif
    .overflow(s_overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  // Scoreboard: every main-DUT write must match the next expected {addr, data}.
  always @(negedge clk1) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr,
                 mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_e.a));
        chk("wr_data", mem_wdata, mon_e.d);
      end
    end
  end

  // Small instance only ever does 4-write loads, so write k lands at address k mod 4.
  int s_wr_cnt = 0;
  always @(negedge clk1) begin
    if (rst_n && s_mem_we) begin
      chk("small_addr", 32'(s_mem_addr), 32'(s_wr_cnt % 4));
      s_wr_cnt++;
    end
  end

  typedef struct {
    int               n_in;
    logic [5:0][31:0] ins;
    int               n_out;
    logic [6:0][31:0] outs;
    int               nops;
  } vec_t;
  vec_t vecs[6];

  task automatic push_exp(input int addr, input logic [31:0] d);
    wr_t e;
    e.a = 10'(addr);
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk1);
      acc = in_ready;
      @(posedge clk1); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %h not accepted, expected accept within 50 cycles", w);
    end
  endtask

  task automatic finish_load();
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk1); #1;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("done", 32'(done), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("no_overflow", 32'(overflow), 32'd0);
  endtask

  task automatic run_vec(input int v);
    pulse_start();
    for (int i = 0; i < vecs[v].n_out; i++) push_exp(i, vecs[v].outs[i]);
    for (int i = 0; i < vecs[v].n_in; i++) send(vecs[v].ins[i]);
    finish_load();
`ifdef NOP_INSERT_STATS_EN
    chk("nop_count", 32'(nop_count), 32'(vecs[v].nops));
    chk("instr_count", 32'(instr_count), 32'(vecs[v].n_in));
`endif
  endtask

  int wcnt;
  int base;

  initial begin
    vecs[0] = '{3, {32'h0, 32'h0, 32'h0, HLT, 32'h0022_2000, 32'h2801_000A},
                5, {32'h0, 32'h0, HLT, 32'h0022_2000, NOP, NOP, 32'h2801_000A}, 2};
    vecs[1] = '{5, {32'h0, HLT, 32'h0022_2000, 32'h2803_0019, 32'h2802_0014, 32'h2801_000A},
                6, {32'h0, HLT, 32'h0022_2000, NOP, 32'h2803_0019, 32'h2802_0014,
                    32'h2801_000A}, 1};
    vecs[2] = '{3, {32'h0, 32'h0, 32'h0, HLT, 32'h0000_2000, 32'h2800_0005},
                3, {32'h0, 32'h0, 32'h0, 32'h0, HLT, 32'h0000_2000, 32'h2800_0005}, 0};
    vecs[3] = '{3, {32'h0, 32'h0, 32'h0, HLT, 32'h2405_0000, 32'h2005_0000},
                5, {32'h0, 32'h0, HLT, 32'h2405_0000, NOP, NOP, 32'h2005_0000}, 2};
    vecs[4] = '{3, {32'h0, 32'h0, 32'h0, HLT, 32'h4020_0000, 32'h2801_000A},
                3, {32'h0, 32'h0, 32'h0, 32'h0, HLT, 32'h4020_0000, 32'h2801_000A}, 0};
    vecs[5] = '{4, {32'h0, 32'h0, HLT, 32'h3820_0000, 32'h2802_0014, 32'h2801_000A},
                5, {32'h0, 32'h0, HLT, 32'h3820_0000, NOP, 32'h2802_0014, 32'h2801_000A}, 1};

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1); #1;

    for (int v = 0; v < 6; v++) run_vec(v);

    // Idle cycles between producer and consumer must not count toward the gap.
    pulse_start();
    chk("busy_in_load", 32'(busy), 32'd1);
    push_exp(0, 32'h2801_000A);
    push_exp(1, NOP);
    push_exp(2, NOP);
    push_exp(3, 32'h0022_2000);
    push_exp(4, HLT);
    send(32'h2801_000A);
    wcnt = 0;
    repeat (5) begin
      @(negedge clk1);
      if (mem_we) wcnt++;
      @(posedge clk1); #1;
    end
    chk("idle_writes", 32'(wcnt), 32'd1);
    send(32'h0022_2000);
    send(HLT);
    finish_load();

    // Restart mid-load: the word offered during the start cycle is dropped.
    pulse_start();
    push_exp(0, 32'h2802_0014);
    push_exp(1, 32'h2803_0019);
    send(32'h2802_0014);
    send(32'h2803_0019);
    start = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h2804_0001;
    @(negedge clk1);
    chk("restart_ready", 32'(in_ready), 32'd0);
    @(posedge clk1); #1;
    start = 1'b0;
    in_valid = 1'b0;
    push_exp(0, 32'h2801_000A);
    push_exp(1, HLT);
    send(32'h2801_000A);
    send(HLT);
    finish_load();
    repeat (4) begin
      @(posedge clk1); #1;
    end
    chk("done_sticky", 32'(done), 32'd1);

    // Small memory: four non-HLT words fill it and the load ends in overflow.
    base = s_wr_cnt;
    s_start = 1'b1;
    @(posedge clk1); #1;
    s_start = 1'b0;
    s_in_valid = 1'b1;
    s_in_instr = 32'h2802_0014;
    repeat (7) begin
      @(posedge clk1); #1;
    end
    @(negedge clk1);
    chk("ovf_ready", 32'(s_in_ready), 32'd0);
    chk("ovf_overflow", 32'(s_overflow), 32'd1);
    chk("ovf_busy", 32'(s_busy), 32'd0);
    chk("ovf_done", 32'(s_done), 32'd0);
    chk("ovf_writes", 32'(s_wr_cnt - base), 32'd4);
    s_in_valid = 1'b0;
    @(posedge clk1); #1;

    // Small memory: HLT in the last slot completes without overflow.
    base = s_wr_cnt;
    s_start = 1'b1;
    @(posedge clk1); #1;
    s_start = 1'b0;
    s_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_in_instr = (i == 3) ? HLT : 32'h2802_0014;
      @(posedge clk1); #1;
    end
    s_in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk1); #1;
    end
    chk("hlt_last_done", 32'(s_done), 32'd1);
    chk("hlt_last_overflow", 32'(s_overflow), 32'd0);
    chk("hlt_last_writes", 32'(s_wr_cnt - base), 32'd4);

    // Asynchronous reset with a write pending on the outputs.
    pulse_start();
    send(32'h2801_000A);
    chk("arst_pre_we", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_mem_we", 32'(mem_we), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk1); #1;
    end
    chk("post_rst_idle_busy", 32'(busy), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
